multi_blink_ctrl: RTL

Parametrised multi-channel LED blink controller for board status lights. It generalises the single fixed-rate toggle counter to N independent channels. Each channel has a run-time programmable period and mode: off, on, blink, or one-shot. All channels share one prescaler tick; a simple write port configures channels.

---
 rtl/multi_blink_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/multi_blink_ctrl.sv
// Multi-channel LED blink controller: N independent channels (off/on/blink/one-shot)
// sharing one prescaler tick, configured through a single-channel write port.
module multi_blink_ctrl #(
    parameter int N        = 4,
    parameter int W        = 26,
    parameter int PRESCALE = 1,
    parameter int CH_W     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [1:0]      wr_mode,
    input  logic [W-1:0]    wr_period,
    output logic [N-1:0]    light,
    output logic [N-1:0]    done,
    output logic [N-1:0]    busy
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick;

    mode_t           mode_q   [N];
    mode_t           mode_d   [N];
    logic [W-1:0]    count_q  [N];
    logic [W-1:0]    count_d  [N];
    logic [W-1:0]    period_q [N];
    logic [W-1:0]    period_d [N];
    logic [N-1:0]    light_q, light_d;
    logic [N-1:0]    done_q, done_d;
    logic [N-1:0]    busy_q, busy_d;

    always_comb begin
        tick = (ps_q == PS_W'(PRESCALE - 1));
        ps_d = tick ? '0 : ps_q + 1'b1;

        for (int unsigned i = 0; i < N; i++) begin
            mode_d[i]   = mode_q[i];
            count_d[i]  = count_q[i];
            period_d[i] = period_q[i];
            light_d[i]  = light_q[i];
            done_d[i]   = 1'b0;

            // Decoding by equality means an out-of-range wr_ch hits no channel;
            // a write also swallows a coincident tick on its own channel.
            if (wr_en && (wr_ch == CH_W'(i))) begin
                mode_d[i]   = mode_t'(wr_mode);
                period_d[i] = wr_period;
                count_d[i]  = '0;
                case (mode_t'(wr_mode))
                    MODE_ON, MODE_ONESHOT: light_d[i] = 1'b1;
                    default:               light_d[i] = 1'b0;
                endcase
            end else if (tick) begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (count_q[i] == period_q[i]) begin
                            light_d[i] = ~light_q[i];
                            count_d[i] = '0;
                        end else begin
                            count_d[i] = count_q[i] + 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (count_q[i] == period_q[i]) begin
                            light_d[i] = 1'b0;
                            mode_d[i]  = MODE_OFF;
                            count_d[i] = '0;
                            done_d[i]  = 1'b1;
                        end else begin
                            count_d[i] = count_q[i] + 1'b1;
                        end
                    end
                    default: count_d[i] = '0;
                endcase
            end

            busy_d[i] = (mode_d[i] == MODE_BLINK) || (mode_d[i] == MODE_ONESHOT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q    <= '0;
            light_q <= '0;
            done_q  <= '0;
            busy_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                mode_q[i]   <= MODE_OFF;
                count_q[i]  <= '0;
                period_q[i] <= '0;
            end
        end else begin
            ps_q    <= ps_d;
            light_q <= light_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            for (int unsigned i = 0; i < N; i++) begin
                mode_q[i]   <= mode_d[i];
                count_q[i]  <= count_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end

    assign light = light_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule
